// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encodings,
// reset-cause codes and the counter-width helper.
package pll_reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'b00,
    ST_STABILIZE = 2'b01,
    ST_HOLD      = 2'b10,
    ST_RUN       = 2'b11
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_POWER_ON  = 2'b00,
    CAUSE_LOCK_LOSS = 2'b01,
    CAUSE_BUTTON    = 2'b10
  } rst_cause_e;

  // A counter that runs 0..n-1 needs $clog2(n) bits; keep at least one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_debounce.sv
// Multi-flop synchronizer followed by a symmetric press/release debouncer.
// With BYPASS_DB set the synchronized level is passed straight through.
module rst_sync_debounce
  import pll_reset_seq_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 256,
  parameter bit   BYPASS_DB       = 1'b0,
  parameter logic DB_RST_VAL      = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_db;
  logic                   w_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // The debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_db_cnt <= '0;
      r_db     <= DB_RST_VAL;
    end else if (w_sync == r_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_db_cnt <= '0;
      r_db     <= w_sync;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign o_level = BYPASS_DB ? w_sync : r_db;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL lock / push-button reset sequencer producing a registered active-low fabric reset.
// Define PLL_RESET_SEQ_LOSS_CNT_EN to build the saturating lock-loss event counter.
module pll_reset_sequencer
  import pll_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES    = 256
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  input  logic       EXT_RST_N,
  output logic       FABRIC_RESET_N,
  output logic       LOCK_SYNC,
  output logic [1:0] SEQ_STATE,
  output logic [1:0] RESET_CAUSE,
  output logic [7:0] LOCK_LOSS_CNT
);

  localparam int STAB_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int HOLD_W = cnt_width(RST_HOLD_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  seq_state_e        r_state, w_state_nxt;
  rst_cause_e        r_cause, w_cause_nxt;
  logic [STAB_W-1:0] r_stab_cnt, w_stab_cnt_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic              r_fabric_rst_n;
  logic              w_lock_sync;
  logic              w_btn_db;
  logic              w_btn_press;

  rst_sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BYPASS_DB       (1'b1),
    .DB_RST_VAL      (1'b0)
  ) u_lock_sync (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_async (PLL_LOCK),
    .o_level (w_lock_sync)
  );

  rst_sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BYPASS_DB       (1'b0),
    .DB_RST_VAL      (1'b1)
  ) u_btn_debounce (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_async (EXT_RST_N),
    .o_level (w_btn_db)
  );

  assign w_btn_press = ~w_btn_db;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state        <= ST_WAIT_LOCK;
      r_cause        <= CAUSE_POWER_ON;
      r_stab_cnt     <= '0;
      r_hold_cnt     <= '0;
      r_fabric_rst_n <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cause        <= w_cause_nxt;
      r_stab_cnt     <= w_stab_cnt_nxt;
      r_hold_cnt     <= w_hold_cnt_nxt;
      r_fabric_rst_n <= (w_state_nxt == ST_RUN);
    end
  end

  // Lock loss is tested before the button so it wins when both arrive together.
  always_comb begin
    w_state_nxt    = r_state;
    w_cause_nxt    = r_cause;
    w_stab_cnt_nxt = r_stab_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_lock_sync) begin
          w_state_nxt    = ST_STABILIZE;
          w_stab_cnt_nxt = '0;
        end
      end
      ST_STABILIZE: begin
        if (!w_lock_sync) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_stab_cnt == STAB_LAST) begin
          w_state_nxt    = ST_HOLD;
          w_stab_cnt_nxt = '0;
          w_hold_cnt_nxt = '0;
        end else begin
          w_stab_cnt_nxt = r_stab_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!w_lock_sync) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cause_nxt = CAUSE_LOCK_LOSS;
        end else if (w_btn_press) begin
          w_hold_cnt_nxt = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!w_lock_sync) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cause_nxt = CAUSE_LOCK_LOSS;
        end else if (w_btn_press) begin
          w_state_nxt    = ST_HOLD;
          w_cause_nxt    = CAUSE_BUTTON;
          w_hold_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  logic [7:0] r_loss_cnt;
  logic       w_loss_evt;

  assign w_loss_evt = ((r_state == ST_HOLD) || (r_state == ST_RUN)) && !w_lock_sync;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && !(&r_loss_cnt)) begin
      r_loss_cnt <= r_loss_cnt + 1'b1;
    end
  end

  assign LOCK_LOSS_CNT = r_loss_cnt;
`else
  assign LOCK_LOSS_CNT = '0;
`endif

  assign FABRIC_RESET_N = r_fabric_rst_n;
  assign LOCK_SYNC      = w_lock_sync;
  assign SEQ_STATE      = r_state;
  assign RESET_CAUSE    = r_cause;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short sequencing parameters.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_pll_reset_sequencer;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       CLK;
  logic       RESET;
  logic       PLL_LOCK;
  logic       EXT_RST_N;
  logic       FABRIC_RESET_N;
  logic       LOCK_SYNC;
  logic [1:0] SEQ_STATE;
  logic [1:0] RESET_CAUSE;
  logic [7:0] LOCK_LOSS_CNT;

  int checks = 0;
  int errors = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (8),
    .RST_HOLD_CYCLES    (4),
    .DEBOUNCE_CYCLES    (4)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .PLL_LOCK       (PLL_LOCK),
    .EXT_RST_N      (EXT_RST_N),
    .FABRIC_RESET_N (FABRIC_RESET_N),
    .LOCK_SYNC      (LOCK_SYNC),
    .SEQ_STATE      (SEQ_STATE),
    .RESET_CAUSE    (RESET_CAUSE),
    .LOCK_LOSS_CNT  (LOCK_LOSS_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lock up to HOLD, then drop lock and let the FSM fall back to WAIT_LOCK.
  task automatic loss_event();
    PLL_LOCK = 1'b1;
    ticks(12);
    PLL_LOCK = 1'b0;
    ticks(4);
  endtask

  initial begin
    RESET     = 1'b1;
    PLL_LOCK  = 1'b0;
    EXT_RST_N = 1'b1;
    ticks(2);
    chk("rst_fabric", {7'd0, FABRIC_RESET_N}, 8'd0);
    chk("rst_lock_sync", {7'd0, LOCK_SYNC}, 8'd0);
    chk("rst_state", {6'd0, SEQ_STATE}, 8'd0);
    chk("rst_cause", {6'd0, RESET_CAUSE}, 8'd0);
    chk("rst_loss_cnt", LOCK_LOSS_CNT, 8'd0);

    // Power-on: lock rises after edge 0, fabric reset released at edge 15.
    RESET = 1'b0;
    ticks(3);
    chk("po_idle_state", {6'd0, SEQ_STATE}, 8'd0);
    PLL_LOCK = 1'b1;
    ticks(2);
    chk("po_e2_lock_sync", {7'd0, LOCK_SYNC}, 8'd1);
    chk("po_e2_state", {6'd0, SEQ_STATE}, 8'd0);
    tick();
    chk("po_e3_state", {6'd0, SEQ_STATE}, 8'd1);
    ticks(7);
    chk("po_e10_state", {6'd0, SEQ_STATE}, 8'd1);
    tick();
    chk("po_e11_state", {6'd0, SEQ_STATE}, 8'd2);
    ticks(3);
    chk("po_e14_fabric", {7'd0, FABRIC_RESET_N}, 8'd0);
    chk("po_e14_state", {6'd0, SEQ_STATE}, 8'd2);
    tick();
    chk("po_e15_fabric", {7'd0, FABRIC_RESET_N}, 8'd1);
    chk("po_e15_state", {6'd0, SEQ_STATE}, 8'd3);
    chk("po_cause", {6'd0, RESET_CAUSE}, 8'd0);

    // Lock loss in RUN: fabric reset falls 3 edges after lock drops.
    PLL_LOCK = 1'b0;
    ticks(2);
    chk("ll_e2_fabric", {7'd0, FABRIC_RESET_N}, 8'd1);
    chk("ll_e2_lock_sync", {7'd0, LOCK_SYNC}, 8'd0);
    tick();
    chk("ll_e3_fabric", {7'd0, FABRIC_RESET_N}, 8'd0);
    chk("ll_e3_state", {6'd0, SEQ_STATE}, 8'd0);
    chk("ll_cause", {6'd0, RESET_CAUSE}, 8'd1);
    chk("ll_loss_cnt", LOCK_LOSS_CNT, CNT_EN ? 8'd1 : 8'd0);

    // Lock glitch of 3 cycles during STABILIZE restarts the full stabilization.
    PLL_LOCK = 1'b1;
    ticks(3);
    chk("gl_e3_state", {6'd0, SEQ_STATE}, 8'd1);
    ticks(3);
    PLL_LOCK = 1'b0;
    ticks(3);
    chk("gl_e9_state", {6'd0, SEQ_STATE}, 8'd0);
    chk("gl_e9_fabric", {7'd0, FABRIC_RESET_N}, 8'd0);
    PLL_LOCK = 1'b1;
    ticks(3);
    chk("gl_e12_state", {6'd0, SEQ_STATE}, 8'd1);
    ticks(7);
    chk("gl_e19_state", {6'd0, SEQ_STATE}, 8'd1);
    chk("gl_e19_fabric", {7'd0, FABRIC_RESET_N}, 8'd0);
    tick();
    chk("gl_e20_state", {6'd0, SEQ_STATE}, 8'd2);
    ticks(3);
    chk("gl_e23_fabric", {7'd0, FABRIC_RESET_N}, 8'd0);
    tick();
    chk("gl_e24_fabric", {7'd0, FABRIC_RESET_N}, 8'd1);
    chk("gl_cause", {6'd0, RESET_CAUSE}, 8'd1);

    // Short button pulse is ignored.
    EXT_RST_N = 1'b0;
    ticks(2);
    EXT_RST_N = 1'b1;
    ticks(10);
    chk("bs_state", {6'd0, SEQ_STATE}, 8'd3);
    chk("bs_fabric", {7'd0, FABRIC_RESET_N}, 8'd1);

    // Long press: falls at edge 7, release debounced at edge 16, rises at edge 20.
    EXT_RST_N = 1'b0;
    ticks(6);
    chk("bl_e6_fabric", {7'd0, FABRIC_RESET_N}, 8'd1);
    tick();
    chk("bl_e7_fabric", {7'd0, FABRIC_RESET_N}, 8'd0);
    chk("bl_e7_state", {6'd0, SEQ_STATE}, 8'd2);
    chk("bl_cause", {6'd0, RESET_CAUSE}, 8'd2);
    ticks(3);
    EXT_RST_N = 1'b1;
    ticks(9);
    chk("bl_e19_fabric", {7'd0, FABRIC_RESET_N}, 8'd0);
    chk("bl_e19_state", {6'd0, SEQ_STATE}, 8'd2);
    tick();
    chk("bl_e20_fabric", {7'd0, FABRIC_RESET_N}, 8'd1);
    chk("bl_e20_state", {6'd0, SEQ_STATE}, 8'd3);

    // Lock loss and debounced press land on the same edge (7): lock loss wins.
    EXT_RST_N = 1'b0;
    ticks(4);
    PLL_LOCK = 1'b0;
    ticks(2);
    chk("sim_e6_state", {6'd0, SEQ_STATE}, 8'd3);
    tick();
    chk("sim_e7_state", {6'd0, SEQ_STATE}, 8'd0);
    chk("sim_e7_cause", {6'd0, RESET_CAUSE}, 8'd1);
    chk("sim_e7_fabric", {7'd0, FABRIC_RESET_N}, 8'd0);

    // Asynchronous reset in HOLD, then restart from WAIT_LOCK.
    EXT_RST_N = 1'b1;
    PLL_LOCK  = 1'b1;
    ticks(12);
    chk("ar_hold_state", {6'd0, SEQ_STATE}, 8'd2);
    #2 RESET = 1'b1;
    #1;
    chk("ar_hold_async_state", {6'd0, SEQ_STATE}, 8'd0);
    chk("ar_hold_async_fabric", {7'd0, FABRIC_RESET_N}, 8'd0);
    chk("ar_hold_async_lock_sync", {7'd0, LOCK_SYNC}, 8'd0);
    chk("ar_hold_async_cause", {6'd0, RESET_CAUSE}, 8'd0);
    @(negedge CLK);
    RESET = 1'b0;
    ticks(14);
    chk("ar_restart_e14_fabric", {7'd0, FABRIC_RESET_N}, 8'd0);
    chk("ar_restart_e14_state", {6'd0, SEQ_STATE}, 8'd2);
    tick();
    chk("ar_restart_e15_fabric", {7'd0, FABRIC_RESET_N}, 8'd1);

    // Asynchronous reset in RUN drops the fabric reset without a clock edge.
    #2 RESET = 1'b1;
    #1;
    chk("ar_run_async_fabric", {7'd0, FABRIC_RESET_N}, 8'd0);
    chk("ar_run_async_state", {6'd0, SEQ_STATE}, 8'd0);
    chk("ar_run_async_loss_cnt", LOCK_LOSS_CNT, 8'd0);
    PLL_LOCK = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    ticks(2);

    // Lock-loss counter: 10 events, then 300 in total saturating at 255.
    repeat (10) loss_event();
    chk("sat_10_loss_cnt", LOCK_LOSS_CNT, CNT_EN ? 8'd10 : 8'd0);
    chk("sat_10_state", {6'd0, SEQ_STATE}, 8'd0);
    repeat (290) loss_event();
    chk("sat_300_loss_cnt", LOCK_LOSS_CNT, CNT_EN ? 8'd255 : 8'd0);
    chk("sat_300_cause", {6'd0, RESET_CAUSE}, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for PLL_LOCK and EXT_RST_N, legal range 2..4.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: number of consecutive locked cycles required before release, legal range 1..65535.
REQ-003 SHALL have parameter RST_HOLD_CYCLES, default 16: reset hold time after stabilization, legal range 1..255.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 256: push-button debounce time, legal range 1..65535.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock, the PLL fabric clock output.
REQ-006 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port PLL_LOCK, input, 1 bit: PLL lock indication, asynchronous to CLK.
REQ-008 SHALL have port EXT_RST_N, input, 1 bit: board push-button reset, asynchronous, active-low.
REQ-009 SHALL have port FABRIC_RESET_N, output, 1 bit: registered system reset, active-low.
REQ-010 SHALL have port LOCK_SYNC, output, 1 bit: PLL_LOCK after the synchronizer.
REQ-011 SHALL have port SEQ_STATE, output, 2 bits: current FSM state.
REQ-012 SHALL have port RESET_CAUSE, output, 2 bits: 00 = power-on, 01 = lock loss, 10 = external button.
REQ-013 SHALL have port LOCK_LOSS_CNT, output, 8 bits: lock-loss event counter (see Configuration).

Function
REQ-014 SHALL implement FSM states WAIT_LOCK=00, STABILIZE=01, HOLD=10, RUN=11.
REQ-015 WAIT_LOCK SHALL go to STABILIZE on the first edge where LOCK_SYNC=1, clearing the cycle counter.
REQ-016 STABILIZE SHALL count locked cycles and go to HOLD after LOCK_STABLE_CYCLES cycles; LOCK_SYNC=0 at any point SHALL return it to WAIT_LOCK.
REQ-017 HOLD SHALL go to RUN after RST_HOLD_CYCLES cycles; while the debounced button is pressed, the counter SHALL stay at 0.
REQ-018 RUN SHALL drive FABRIC_RESET_N=1; FABRIC_RESET_N SHALL be a register that is set on the edge where the FSM enters RUN.
REQ-019 On LOCK_SYNC=0 in HOLD or RUN, the FSM SHALL go to WAIT_LOCK, FABRIC_RESET_N SHALL fall on that same edge, and RESET_CAUSE SHALL be set to 01.
REQ-020 A debounced button press in RUN SHALL go to HOLD, FABRIC_RESET_N SHALL fall on that edge, and RESET_CAUSE SHALL be set to 10.
REQ-021 When lock loss and button press occur on the same cycle, lock loss SHALL win (WAIT_LOCK, cause 01).
REQ-022 Debounce SHALL register a press only after the synchronized EXT_RST_N is low for DEBOUNCE_CYCLES consecutive cycles, and a release only after it is high for DEBOUNCE_CYCLES consecutive cycles; shorter pulses SHALL be ignored.
REQ-023 From power-up with lock present, FABRIC_RESET_N SHALL rise exactly SYNC_STAGES+1+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES edges after PLL_LOCK rises.
REQ-024 All counters SHALL be sized by $clog2 of their parameter and SHALL never wrap.

Reset
REQ-025 While RESET=1, asynchronously: state WAIT_LOCK, FABRIC_RESET_N=0, LOCK_SYNC=0, synchronizer flops 0, debounced button released, all counters 0, RESET_CAUSE=00, LOCK_LOSS_CNT=0.
REQ-026 Assertion of RESET mid-sequence SHALL abort the sequence immediately; after deassertion, sequencing SHALL restart from WAIT_LOCK.

Configuration
REQ-027 With macro PLL_RESET_SEQ_LOSS_CNT_EN defined, LOCK_LOSS_CNT SHALL increment on each REQ-019 transition and saturate at 255.
REQ-028 Without PLL_RESET_SEQ_LOSS_CNT_EN, the LOCK_LOSS_CNT port SHALL remain and SHALL be tied to 0, and no counter logic SHALL be built.

Structure
REQ-029 A shared package pll_reset_seq_pkg SHALL hold the state encodings and RESET_CAUSE codes.
REQ-030 Synchronizer plus debounce SHALL be one sub-module, rst_sync_debounce, instantiated for EXT_RST_N; the PLL_LOCK synchronizer SHALL reuse its sync stage with debounce bypassed.

Verification (bench params SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, DEBOUNCE_CYCLES=4)
REQ-031 Power-on: RESET released, then PLL_LOCK rises at edge 0 -> FABRIC_RESET_N rises at edge 15, RESET_CAUSE=00.
REQ-032 Lock glitch: PLL_LOCK drops for 3 cycles during STABILIZE -> return to WAIT_LOCK, full 8-cycle stabilization repeated, FABRIC_RESET_N stays 0 throughout.
REQ-033 Lock loss in RUN -> FABRIC_RESET_N falls 3 edges after PLL_LOCK falls, RESET_CAUSE=01, LOCK_LOSS_CNT=1 (macro on) or 0 (macro off).
REQ-034 Button: EXT_RST_N low for 2 cycles in RUN -> no effect; low for 10 cycles -> FABRIC_RESET_N falls 7 edges after the falling edge, cause 10, and rises 4 edges after the debounced release.
REQ-035 Simultaneous lock loss and debounced press -> state WAIT_LOCK, cause 01; RESET pulsed mid-HOLD -> FABRIC_RESET_N=0 asynchronously, SEQ_STATE=00.
REQ-036 Saturation: 300 lock-loss events with macro on -> LOCK_LOSS_CNT=255.
